// File: rtl/uart_axi_pkg.sv
// Shared types and constants for the requester-to-AXI-Lite register arbiter.
package uart_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans from last_grant+1 upward with wrap.
// Zero latency; a request simply waits until it is the first valid one in scan order.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_grant) + k) % N);
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_lite_reg_arbiter.sv
// Shares one AXI-Lite master among NUM_REQ command ports, one transaction in flight.
// Grant in IDLE, response pulse registered one cycle after the B/R handshake; slave stalls wait forever.
module axi_lite_reg_arbiter
    import uart_axi_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int SW         = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*SW-1:0]         req_wstrb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         m_awaddr,
    output logic [2:0]                    m_awprot,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic [SW-1:0]                 m_wstrb,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [2:0]                    m_arprot,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rvalid,
    output logic                          m_rready
);

    arb_state_t            state_q;
    logic [IW-1:0]         last_grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         wstrb_q;
    logic                  awvalid_q, wvalid_q, aw_done_q, w_done_q;
    logic                  bready_q, arvalid_q, rready_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic [NUM_REQ-1:0]    grant;
    logic [IW-1:0]         grant_idx;
    logic                  any_grant;
    logic                  can_grant;
    logic                  aw_hs, w_hs;
    logic                  unused_resp_lsb;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    // The response cycle is still IDLE but is kept grant-free, forcing a gap between transactions.
    assign can_grant = (state_q == IDLE) && (rsp_valid_q == '0) && !rst;
    assign req_ready = can_grant ? grant : '0;

    assign aw_hs = awvalid_q && m_awready;
    assign w_hs  = wvalid_q && m_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NUM_REQ - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (can_grant && any_grant) begin
                        last_grant_q <= grant_idx;
                        addr_q       <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q      <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        wstrb_q      <= req_wstrb[grant_idx*SW +: SW];
                        if (req_write[grant_idx]) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_bvalid) begin
                        bready_q                  <= 1'b0;
                        rsp_valid_q[last_grant_q] <= 1'b1;
                        rsp_rdata_q               <= '0;
                        rsp_err_q                 <= m_bresp[1];
                        state_q                   <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_rvalid) begin
                        rready_q                  <= 1'b0;
                        rsp_valid_q[last_grant_q] <= 1'b1;
                        rsp_rdata_q               <= m_rdata;
                        rsp_err_q                 <= m_rresp[1];
                        state_q                   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Only resp[1] distinguishes error from okay; EXOKAY is not used on AXI-Lite.
    assign unused_resp_lsb = ^{m_bresp[0], m_rresp[0]};

    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_awprot  = 3'b000;
    assign m_arprot  = 3'b000;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
